hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage core. Sits beside the operand forwarding unit in ID/EX.
- Detects hazards that forwarding cannot cover:
  - load-use;
  - HI/LO or mult/div use while the multi-cycle multiply/divide unit is busy;
  - taken branches;
  - data-memory wait.
- Drives the PC and pipeline-register enables and flushes, and keeps saturating stall/flush performance counters.

Parameters:
- MD_CYCLES, 8, execute latency of the mult/div unit in cycles (>=2).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_md_use  in  1  ID instruction is mult/div or mfhi/mflo/mthi/mtlo.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_reg_write  in  1  instruction in EX writes the register file.
- ex_wn  in  5  destination register of the EX instruction.
- ex_md_start  in  1  mult/div instruction is issuing in EX this cycle.
- branch_taken  in  1  branch/jump resolved taken in EX.
- mem_wait  in  1  data memory not ready; the whole pipe must freeze.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID register enable.
- idex_en  out  1  ID/EX register enable.
- exmem_en  out  1  EX/MEM and MEM/WB enable.
- ifid_flush  out  1  zero IF/ID on next edge.
- idex_flush  out  1  insert bubble into ID/EX on next edge.
- md_busy  out  1  mult/div unit occupied.
- md_done  out  1  one-cycle pulse when the mult/div result becomes valid.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of branch flushes.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst_n=0:
  - all enables = 0, flushes = 0;
  - md_busy = 0, md_done = 0;
  - counters = 0, FSM = S_RUN, md counter = 0.
- After release, outputs take their normal values from the first clk edge onward.
- Hazard terms (combinational):
  - lu = ex_mem_read & ex_reg_write & (ex_wn!=0) & ((id_uses_rs & id_rs==ex_wn) | (id_uses_rt & id_rt==ex_wn)).
  - mdh = id_md_use & md_busy.
- Priority and output settings (highest first):
  1. mem_wait: pc_en = ifid_en = idex_en = exmem_en = 0; no flushes.
  2. branch_taken: all enables 1; ifid_flush = 1, idex_flush = 1. Any lu or mdh in the same cycle is discarded, because the ID instruction is squashed.
  3. mdh or lu: pc_en = 0, ifid_en = 0, idex_en = 1, exmem_en = 1, idex_flush = 1 (bubble).
  4. Otherwise: all enables 1, no flushes.
- Latency:
  - load-use costs exactly 1 bubble; on the next cycle the load is in MEM and forwarding covers it.
  - mdh stalls until md_busy falls.
- Mult/div FSM: states S_RUN and S_MD.
  - S_RUN -> S_MD on ex_md_start & ~mem_wait; md counter loads MD_CYCLES-1.
  - In S_MD: counter decrements every cycle, independent of mem_wait, because the unit runs autonomously.
  - When the counter reaches 1: next edge returns to S_RUN and pulses md_done for one cycle.
  - md_busy = (state==S_MD).
  - ex_md_start in S_MD cannot legally occur (mdh blocks issue). If asserted anyway, the counter reloads to MD_CYCLES-1 and the FSM stays in S_MD; md_done is not pulsed for the aborted op.
  - branch_taken does not cancel an in-flight mult/div.
- Counters:
  - stall_cnt increments on every edge where priority 1 or 3 is active.
  - flush_cnt increments on every edge where priority 2 is active.
  - Both saturate at all-ones; neither wraps.
- Reset mid-operation: asynchronous clear of FSM, counters and pulses. An in-flight mult/div is abandoned and md_done does not pulse.

Test Plan:
- Load-use: lw writing $8 in EX, ID add reads rs=8 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, then all enables 1; stall_cnt=1.
- $0 destination: ex_wn=0 with a load in EX, id_rs=0 -> no stall.
- Mult/div stall, MD_CYCLES=8: ex_md_start at cycle 0, then mflo in ID at cycle 1 -> md_busy high for cycles 1-7, stall held for cycles 1-7, md_done at cycle 8; stall_cnt=7.
- Branch vs load-use: branch_taken and lu in the same cycle -> ifid_flush=1, idex_flush=1, pc_en=1, no stall; flush_cnt=1, stall_cnt=0.
- mem_wait during mult/div: mem_wait high for 3 cycles mid-op -> all enables 0; md counter still expires MD_CYCLES after issue; stall_cnt += 3.
- Async reset mid-op: rst_n low at cycle 4 of a mult/div -> md_busy=0 and counters 0 immediately, with no md_done. Separately, force stall_cnt to its max value, then continue stalling -> it holds at 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage core. It covers load-use, mult/div
// occupancy, taken branches and data-memory wait, and keeps saturating stall/flush counters.
module hazard_ctrl #(
    parameter int MD_CYCLES = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_md_use,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_wn,
    input  logic             ex_md_start,
    input  logic             branch_taken,
    input  logic             mem_wait,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int               MDC_W   = $clog2(MD_CYCLES + 1);
    localparam logic [MDC_W-1:0] MD_LOAD = MDC_W'(MD_CYCLES - 1);
    localparam logic [MDC_W-1:0] MD_LAST = MDC_W'(1);

    typedef enum logic [0:0] {
        S_RUN = 1'b0,
        S_MD  = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [MDC_W-1:0] md_cnt_r, md_cnt_s;
    logic             md_done_r, md_done_s;
    logic             run_r;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
    logic             lu_s, mdh_s, stall_evt_s, flush_evt_s;

    // Hazards that forwarding cannot resolve; writes to $0 never create a dependency.
    always_comb begin
        lu_s  = ex_mem_read & ex_reg_write & (ex_wn != 5'd0) &
                ((id_uses_rs & (id_rs == ex_wn)) | (id_uses_rt & (id_rt == ex_wn)));
        mdh_s = id_md_use & (state_r == S_MD);
    end

    // Priority decode of pipeline enables/flushes; everything is held off until the first edge after reset.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        stall_evt_s = 1'b0;
        flush_evt_s = 1'b0;
        if (!run_r) begin
            pc_en = 1'b0;
        end else if (mem_wait) begin
            stall_evt_s = 1'b1;
        end else if (branch_taken) begin
            // The squashed ID instruction makes any simultaneous lu/mdh irrelevant.
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_evt_s = 1'b1;
        end else if (lu_s | mdh_s) begin
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            idex_flush  = 1'b1;
            stall_evt_s = 1'b1;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
        end
    end

    // Mult/div occupancy FSM; the unit counts down regardless of mem_wait once issued.
    always_comb begin
        state_s   = state_r;
        md_cnt_s  = md_cnt_r;
        md_done_s = 1'b0;
        case (state_r)
            S_RUN: begin
                if (ex_md_start & ~mem_wait) begin
                    state_s  = S_MD;
                    md_cnt_s = MD_LOAD;
                end else begin
                    md_cnt_s = {MDC_W{1'b0}};
                end
            end
            S_MD: begin
                if (ex_md_start) begin
                    md_cnt_s = MD_LOAD;
                end else if (md_cnt_r == MD_LAST) begin
                    state_s   = S_RUN;
                    md_cnt_s  = {MDC_W{1'b0}};
                    md_done_s = 1'b1;
                end else begin
                    md_cnt_s = md_cnt_r - MD_LAST;
                end
            end
            default: begin
                state_s  = S_RUN;
                md_cnt_s = {MDC_W{1'b0}};
            end
        endcase
    end

    // State, pulse and saturating counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_RUN;
            md_cnt_r    <= {MDC_W{1'b0}};
            md_done_r   <= 1'b0;
            run_r       <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            md_cnt_r  <= md_cnt_s;
            md_done_r <= md_done_s;
            run_r     <= 1'b1;
            if (stall_evt_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (flush_evt_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

    assign md_busy   = (state_r == S_MD);
    assign md_done   = md_done_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a cycle-timestamp model checked every negedge, plus directed
// scenarios with hand-computed literal expectations.
module tb_hazard_ctrl;

    localparam int MD_CYCLES = 8;
    localparam int CNT_W     = 16;
    localparam int MAXC      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_wn;
    logic             id_uses_rs, id_uses_rt, id_md_use;
    logic             ex_mem_read, ex_reg_write, ex_md_start, branch_taken, mem_wait;
    logic             pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
    logic             md_busy, md_done;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl #(.MD_CYCLES(MD_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_md_use(id_md_use), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_wn(ex_wn), .ex_md_start(ex_md_start), .branch_taken(branch_taken),
        .mem_wait(mem_wait), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Model: cycle index since reset, timestamp of the last mult/div issue, plain integer counters.
    int cyc, issue_t, m_stall, m_flush;
    bit issue_v, started;

    function automatic bit m_busy();
        return issue_v && (cyc - issue_t) >= 1 && (cyc - issue_t) <= MD_CYCLES - 1;
    endfunction

    function automatic bit m_done();
        return issue_v && (cyc - issue_t) == MD_CYCLES;
    endfunction

    // 0 = normal, 1 = memory freeze, 2 = branch flush, 3 = bubble
    function automatic int m_cls();
        bit lu;
        lu = ex_mem_read && ex_reg_write && ex_wn != 5'd0 &&
             ((id_uses_rs && id_rs == ex_wn) || (id_uses_rt && id_rt == ex_wn));
        if (mem_wait) return 1;
        if (branch_taken) return 2;
        if (lu || (id_md_use && m_busy())) return 3;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; issue_t <= 0; issue_v <= 1'b0; started <= 1'b0;
            m_stall <= 0; m_flush <= 0;
        end else begin
            cyc     <= cyc + 1;
            started <= 1'b1;
            if (ex_md_start && (m_busy() || !mem_wait)) begin
                issue_v <= 1'b1;
                issue_t <= cyc;
            end
            if (started && (m_cls() == 1 || m_cls() == 3)) m_stall <= (m_stall < MAXC) ? m_stall + 1 : MAXC;
            if (started && m_cls() == 2) m_flush <= (m_flush < MAXC) ? m_flush + 1 : MAXC;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [5:0] exp_ctl;
        logic [7:0] exp_v, got_v;
        case (m_cls())
            1:       exp_ctl = 6'b0000_00;
            2:       exp_ctl = 6'b1111_11;
            3:       exp_ctl = 6'b0011_01;
            default: exp_ctl = 6'b1111_00;
        endcase
        if (!started) exp_ctl = 6'b0;
        exp_v = {exp_ctl, m_busy(), m_done()};
        got_v = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, md_busy, md_done};
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL ctrl t=%0t got %b expected %b (pc,ifid,idex,exmem,ifl,idfl,busy,done)", $time, got_v, exp_v);
        end
        n_tests++;
        if (stall_cnt !== CNT_W'(m_stall)) begin
            n_fail++;
            $display("FAIL stall_cnt t=%0t got %0d expected %0d", $time, stall_cnt, m_stall);
        end
        n_tests++;
        if (flush_cnt !== CNT_W'(m_flush)) begin
            n_fail++;
            $display("FAIL flush_cnt t=%0t got %0d expected %0d", $time, flush_cnt, m_flush);
        end
    end

    task automatic lit(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_wn = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_md_use = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_md_start = 1'b0;
        branch_taken = 1'b0; mem_wait = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick(2);
        lit("reset_pc_en", int'(pc_en), 0);
        lit("reset_stall", int'(stall_cnt), 0);
        rst_n = 1'b1;
        tick(2);

        // Load-use on rs = $8: one bubble, then free flow.
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_wn = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        #3 lit("lu_pc_en", int'(pc_en), 0);
        lit("lu_idex_flush", int'(idex_flush), 1);
        tick(1);
        ex_mem_read = 1'b0; ex_reg_write = 1'b0;
        #3 lit("lu_after_pc_en", int'(pc_en), 1);
        tick(1);
        lit("lu_stall_cnt", int'(stall_cnt), 1);
        idle();

        // Load-use on rt via the second operand.
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_wn = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; id_rs = 5'd9;
        tick(1);
        idle();
        lit("lu_rt_stall_cnt", int'(stall_cnt), 2);

        // $0 destination never stalls.
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_wn = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #3 lit("zero_pc_en", int'(pc_en), 1);
        tick(1);
        idle();

        // Mult/div issue then mflo in ID: 7 stall cycles, md_done at cycle 8.
        ex_md_start = 1'b1;
        tick(1);
        ex_md_start = 1'b0; id_md_use = 1'b1;
        #3 lit("md_busy_c1", int'(md_busy), 1);
        tick(6);
        #3 lit("md_busy_c7", int'(md_busy), 1);
        lit("md_pc_en_c7", int'(pc_en), 0);
        tick(1);
        #3 lit("md_done_c8", int'(md_done), 1);
        lit("md_pc_en_c8", int'(pc_en), 1);
        lit("md_stall_cnt", int'(stall_cnt), 9);
        tick(1);
        idle();

        // Branch taken coincident with load-use: flush wins, no stall.
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_wn = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        branch_taken = 1'b1;
        #3 lit("br_ifid_flush", int'(ifid_flush), 1);
        lit("br_pc_en", int'(pc_en), 1);
        tick(1);
        idle();
        lit("br_flush_cnt", int'(flush_cnt), 1);
        lit("br_stall_cnt", int'(stall_cnt), 9);

        // mem_wait for 3 cycles mid-op: unit still finishes MD_CYCLES after issue.
        ex_md_start = 1'b1;
        tick(1);
        ex_md_start = 1'b0;
        tick(2);
        mem_wait = 1'b1;
        #3 lit("mw_exmem_en", int'(exmem_en), 0);
        tick(3);
        mem_wait = 1'b0;
        tick(2);
        #3 lit("mw_md_done", int'(md_done), 1);
        lit("mw_stall_cnt", int'(stall_cnt), 12);
        tick(1);

        // mem_wait blocks a new issue.
        ex_md_start = 1'b1; mem_wait = 1'b1;
        tick(1);
        idle();
        lit("mw_no_issue", int'(md_busy), 0);

        // Illegal restart while busy: counter reloads, done only for the new op.
        ex_md_start = 1'b1;
        tick(1);
        ex_md_start = 1'b0;
        tick(2);
        ex_md_start = 1'b1;
        tick(1);
        ex_md_start = 1'b0;
        tick(6);
        #3 lit("restart_busy", int'(md_busy), 1);
        tick(1);
        #3 lit("restart_done", int'(md_done), 1);
        tick(2);

        // Async reset during cycle 4 of an op: immediate clear, no md_done afterwards.
        ex_md_start = 1'b1;
        tick(1);
        ex_md_start = 1'b0;
        tick(3);
        #1 rst_n = 1'b0;
        #1 lit("rst_md_busy", int'(md_busy), 0);
        lit("rst_stall_cnt", int'(stall_cnt), 0);
        lit("rst_flush_cnt", int'(flush_cnt), 0);
        tick(2);
        rst_n = 1'b1;
        tick(10);

        // Saturation: freeze long enough to exceed the counter range.
        mem_wait = 1'b1;
        tick(MAXC + 5);
        lit("sat_stall_cnt", int'(stall_cnt), 65535);
        tick(2);
        lit("sat_stall_hold", int'(stall_cnt), 65535);
        mem_wait = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
